alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer wrapped around the shared combinational MIPS ALU. Accepts one instruction and its two register operands over a valid/ready handshake, and registers the instruction and operands into the ALU. Captures the ALU's result and zon flags and returns them over a second valid/ready handshake. Owns the architectural HI/LO pair, models mult/div latency with a down-counter, and executes mfhi/mflo/mthi/mtlo locally. The ALU is instantiated beside this block at the execute-stage top level.

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_seq_hilo.sv | 23 ++
 rtl/alu_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU sequencer: FSM states, MIPS opcode/func
// fields it decodes, and zon flag bit positions.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        MULDIV = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_ADD   = 6'b100000;
    localparam logic [5:0] FUNC_SUB   = 6'b100010;

    localparam int ZON_ZERO = 2;
    localparam int ZON_OVF  = 1;
    localparam int ZON_NEG  = 0;

    // Flag pattern reported for a divide by zero: only the overflow/div0 bit set.
    localparam logic [2:0] ZON_DIV0 = 3'(1 << ZON_OVF);

endpackage

// File: rtl/alu_seq_hilo.sv
// Architectural HI/LO register pair with independent write enables.
module alu_seq_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_d,
    input  logic [31:0] lo_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer around the shared MIPS ALU: request/response handshakes,
// HI/LO ownership and mult/div latency. Optional macro: ALU_SEQ_OVF_TRAP_EN.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  zon,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_gr1,
    output logic [31:0] alu_gr2,
    input  logic [31:0] alu_c,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic [2:0]  alu_zon,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef ALU_SEQ_OVF_TRAP_EN
    ,
    output logic        ovf_trap
`endif
);

    // The counter is sized for DIV_LAT; MULT_LAT must not exceed it.
    localparam int CW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi, pend_lo;
    logic [2:0]    pend_zon;
    logic          hi_we, lo_we;
    logic [31:0]   hi_d, lo_d;

    logic [5:0] opcode, func;
    logic       special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mul, is_div, div_zero;

    assign opcode   = alu_instr[31:26];
    assign func     = alu_instr[5:0];
    assign special  = (opcode == OP_SPECIAL);
    assign is_mfhi  = special && (func == FUNC_MFHI);
    assign is_mflo  = special && (func == FUNC_MFLO);
    assign is_mthi  = special && (func == FUNC_MTHI);
    assign is_mtlo  = special && (func == FUNC_MTLO);
    assign is_mul   = special && ((func == FUNC_MULT) || (func == FUNC_MULTU));
    assign is_div   = special && ((func == FUNC_DIV) || (func == FUNC_DIVU));
    assign div_zero = is_div && (alu_gr2 == '0);

`ifdef ALU_SEQ_OVF_TRAP_EN
    logic trap_op;
    assign trap_op = (opcode == OP_ADDI) ||
                     (special && ((func == FUNC_ADD) || (func == FUNC_SUB)));
`endif

    alu_seq_hilo u_hilo (
        .clk   (clk),
        .rst   (rst),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_d  (hi_d),
        .lo_d  (lo_d),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // HI/LO writes land on the edge that enters RESP, so they appear with out_valid.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_d       = pend_hi;
        lo_d       = pend_lo;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = EXEC;
            end
            EXEC: begin
                next_state = (is_mul || is_div) ? MULDIV : RESP;
                if (is_mthi) begin
                    hi_we = 1'b1;
                    hi_d  = alu_gr1;
                end
                if (is_mtlo) begin
                    lo_we = 1'b1;
                    lo_d  = alu_gr1;
                end
            end
            MULDIV: begin
                if (cnt == '0) begin
                    next_state = RESP;
                    hi_we      = !div_zero;
                    lo_we      = !div_zero;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_instr <= '0;
            alu_gr1   <= '0;
            alu_gr2   <= '0;
            result    <= '0;
            zon       <= '0;
            cnt       <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_zon  <= '0;
`ifdef ALU_SEQ_OVF_TRAP_EN
            ovf_trap  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_instr <= instr;
                        alu_gr1   <= op_a;
                        alu_gr2   <= op_b;
                    end
                end
                EXEC: begin
                    if (is_mfhi) begin
                        result <= hi;
                        zon    <= '0;
                    end else if (is_mflo) begin
                        result <= lo;
                        zon    <= '0;
                    end else if (is_mthi || is_mtlo) begin
                        result <= '0;
                        zon    <= '0;
                    end else if (is_mul || is_div) begin
                        pend_hi  <= alu_hi;
                        pend_lo  <= alu_lo;
                        pend_zon <= alu_zon;
                        cnt      <= is_div ? DIV_CNT : MULT_CNT;
                    end else begin
`ifdef ALU_SEQ_OVF_TRAP_EN
                        if (trap_op && alu_zon[ZON_OVF]) begin
                            result   <= '0;
                            ovf_trap <= 1'b1;
                        end else begin
                            result <= alu_c;
                        end
`else
                        result <= alu_c;
`endif
                        zon <= alu_zon;
                    end
                end
                MULDIV: begin
                    if (cnt == '0) begin
                        result <= '0;
                        zon    <= div_zero ? ZON_DIV0 : pend_zon;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
`ifdef ALU_SEQ_OVF_TRAP_EN
                    if (out_ready) ovf_trap <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU model standing in for
// the shared ALU; stimulus pushes expectations, a monitor checks each response.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
`ifdef ALU_SEQ_OVF_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, op_a, op_b, result, alu_instr, alu_gr1, alu_gr2;
    logic [31:0] alu_c, alu_hi, alu_lo, hi, lo;
    logic [2:0]  zon, alu_zon;
    logic        trap_obs;
`ifdef ALU_SEQ_OVF_TRAP_EN
    logic        ovf_trap;
    assign trap_obs = ovf_trap;
`else
    assign trap_obs = 1'b0;
`endif

    alu_seq_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zon(zon),
        .alu_instr(alu_instr), .alu_gr1(alu_gr1), .alu_gr2(alu_gr2),
        .alu_c(alu_c), .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_zon(alu_zon),
        .hi(hi), .lo(lo)
`ifdef ALU_SEQ_OVF_TRAP_EN
        , .ovf_trap(ovf_trap)
`endif
    );

    // Behavioural stand-in for the shared combinational ALU.
    logic [63:0] md;
    logic        ovf_m;
    always_comb begin
        alu_c   = '0;
        alu_hi  = '0;
        alu_lo  = '0;
        alu_zon = '0;
        md      = '0;
        ovf_m   = 1'b0;
        if (alu_instr[31:26] == OP_SPECIAL) begin
            case (alu_instr[5:0])
                FUNC_ADD: begin
                    alu_c   = alu_gr1 + alu_gr2;
                    ovf_m   = (alu_gr1[31] == alu_gr2[31]) && (alu_c[31] != alu_gr1[31]);
                    alu_zon = {alu_c == 0, ovf_m, alu_c[31]};
                end
                FUNC_ADDU: begin
                    alu_c   = alu_gr1 + alu_gr2;
                    alu_zon = {alu_c == 0, 1'b0, alu_c[31]};
                end
                FUNC_SUB: begin
                    alu_c   = alu_gr1 - alu_gr2;
                    ovf_m   = (alu_gr1[31] != alu_gr2[31]) && (alu_c[31] != alu_gr1[31]);
                    alu_zon = {alu_c == 0, ovf_m, alu_c[31]};
                end
                FUNC_OR: begin
                    alu_c   = alu_gr1 | alu_gr2;
                    alu_zon = {alu_c == 0, 1'b0, alu_c[31]};
                end
                FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
                    if (alu_instr[5:0] == FUNC_MULT)
                        md = {{32{alu_gr1[31]}}, alu_gr1} * {{32{alu_gr2[31]}}, alu_gr2};
                    else if (alu_instr[5:0] == FUNC_MULTU)
                        md = {32'b0, alu_gr1} * {32'b0, alu_gr2};
                    else if (alu_gr2 == 0)
                        ovf_m = 1'b1;
                    else if (alu_instr[5:0] == FUNC_DIV) begin
                        md[31:0]  = $signed(alu_gr1) / $signed(alu_gr2);
                        md[63:32] = $signed(alu_gr1) % $signed(alu_gr2);
                    end else begin
                        md[31:0]  = alu_gr1 / alu_gr2;
                        md[63:32] = alu_gr1 % alu_gr2;
                    end
                    alu_hi  = md[63:32];
                    alu_lo  = md[31:0];
                    alu_zon = {md == 0, ovf_m, md[63]};
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [2:0]  zon;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          acc;
        logic        trap;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {OP_SPECIAL, 20'b0, f};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got timeout, want event", name);
    endtask

    // Issue one request; when track is set, push its expected response.
    task automatic applyStimulus(input string name, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eres, input logic [2:0] ezon,
                                 input logic [31:0] ehi, input logic [31:0] elo,
                                 input int lat, input logic etrap, input bit track);
        exp_t e;
        bit   ok;
        @(negedge clk);
        in_valid = 1'b1;
        instr    = ins;
        op_a     = a;
        op_b     = b;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            flagFail({name, "_accept"});
            in_valid = 1'b0;
            return;
        end
        e = '{name, eres, ezon, ehi, elo, lat, cyc, etrap};
        if (track) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr    = '0;
        op_a     = '0;
        op_b     = '0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) return;
        end
        flagFail({name, "_drain"});
        sb.delete();
    endtask

    // Monitor: each rising out_valid must match the oldest expectation.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_resp: got result 0x%08h, want no response", result);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
                    checkOutput({e.name, "_res"}, result, e.res);
                    checkOutput({e.name, "_zon"}, 32'(zon), 32'(e.zon));
                    checkOutput({e.name, "_hi"}, hi, e.hi);
                    checkOutput({e.name, "_lo"}, lo, e.lo);
                    if (TRAP_ON) checkOutput({e.name, "_trap"}, 32'(trap_obs), 32'(e.trap));
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_zon", 32'(zon), 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_alu_instr", alu_instr, 32'd0);
        checkOutput("rst_alu_gr1", alu_gr1, 32'd0);
        checkOutput("rst_alu_gr2", alu_gr2, 32'd0);
        rst = 1'b0;

        applyStimulus("addu", rtype(FUNC_ADDU), 32'd5, 32'd7, 32'd12, 3'b000, 32'd0, 32'd0, 2, 1'b0, 1'b1);
        waitDrain("addu");
        applyStimulus("add_ovf", rtype(FUNC_ADD), 32'h7FFF_FFFF, 32'd1,
                      TRAP_ON ? 32'd0 : 32'h8000_0000, 3'b011, 32'd0, 32'd0, 2, TRAP_ON, 1'b1);
        waitDrain("add_ovf");
        applyStimulus("mult", rtype(FUNC_MULT), 32'hFFFF_FFFD, 32'd4, 32'd0, 3'b001,
                      32'hFFFF_FFFF, 32'hFFFF_FFF4, 2 + MULT_LAT, 1'b0, 1'b1);
        waitDrain("mult");
        applyStimulus("mflo", rtype(FUNC_MFLO), 32'd0, 32'd0, 32'hFFFF_FFF4, 3'b000,
                      32'hFFFF_FFFF, 32'hFFFF_FFF4, 2, 1'b0, 1'b1);
        waitDrain("mflo");
        applyStimulus("mthi", rtype(FUNC_MTHI), 32'hAA, 32'd0, 32'd0, 3'b000,
                      32'hAA, 32'hFFFF_FFF4, 2, 1'b0, 1'b1);
        waitDrain("mthi");
        applyStimulus("mtlo", rtype(FUNC_MTLO), 32'h55, 32'd0, 32'd0, 3'b000,
                      32'hAA, 32'h55, 2, 1'b0, 1'b1);
        waitDrain("mtlo");
        applyStimulus("div0", rtype(FUNC_DIV), 32'd7, 32'd0, 32'd0, 3'b010,
                      32'hAA, 32'h55, 2 + DIV_LAT, 1'b0, 1'b1);
        waitDrain("div0");
        applyStimulus("mfhi", rtype(FUNC_MFHI), 32'd0, 32'd0, 32'hAA, 3'b000,
                      32'hAA, 32'h55, 2, 1'b0, 1'b1);
        waitDrain("mfhi");
        applyStimulus("sub_neg", rtype(FUNC_SUB), 32'd3, 32'd5, 32'hFFFF_FFFE, 3'b001,
                      32'hAA, 32'h55, 2, 1'b0, 1'b1);
        waitDrain("sub_neg");
        applyStimulus("divu", rtype(FUNC_DIVU), 32'd100, 32'd7, 32'd0, 3'b000,
                      32'd2, 32'd14, 2 + DIV_LAT, 1'b0, 1'b1);
        waitDrain("divu");
        applyStimulus("unknown", {6'b111111, 26'h0ABCDEF}, 32'd9, 32'd9, 32'd0, 3'b000,
                      32'd2, 32'd14, 2, 1'b0, 1'b1);
        waitDrain("unknown");

        // Response held off for five cycles must stay put and block new requests.
        out_ready = 1'b0;
        applyStimulus("or_stall", rtype(FUNC_OR), 32'hF0, 32'h0F, 32'hFF, 3'b000,
                      32'd2, 32'd14, 2, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        repeat (5) begin
            checkOutput("stall_result", result, 32'hFF);
            checkOutput("stall_zon", 32'(zon), 32'd0);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("stall_release_out_valid", 32'(out_valid), 32'd0);
        waitDrain("or_stall");

        // Reset three cycles into a divide's MULDIV phase discards it entirely.
        applyStimulus("div_rst", rtype(FUNC_DIV), 32'd100, 32'd7, 32'd0, 3'b000,
                      32'd0, 32'd0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_hi", hi, 32'd0);
        checkOutput("midrst_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        applyStimulus("addu_post_rst", rtype(FUNC_ADDU), 32'd1, 32'd2, 32'd3, 3'b000,
                      32'd0, 32'd0, 2, 1'b0, 1'b1);
        waitDrain("addu_post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
